pulse_prolong_arb: RTL and testbench

PULSE_PROLONG_ARB -- requirements
Module: pulse_prolong_arb

---
 rtl/pulse_prolong_arb.sv | 178 +++++++++++++++++
 tb/tb_pulse_prolong_arb.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_prolong_arb.sv
// ---------------------------------------------------------------------------
// pulse_prolong_arb
//
// Round-robin arbiter that funnels single-cycle event strobes from N
// requesters into one stretched pulse channel. Each grant drives out_pulse
// high for HOLD cycles, then low for GAP cycles, so a slower downstream
// domain reliably sees every granted event.
//
// Ports
//   clk1        single clock, rising edge
//   nrst        asynchronous active-low reset
//   req_pulse   [N] per-requester event strobes
//   out_pulse   stretched pulse (high during HOLD)
//   sel_id      index of requester owning the current/last grant
//   busy        high during HOLD and GAP
//   done_pulse  one-cycle strobe in the first GAP cycle
//   pending     [N] registered outstanding-event flags
//   overflow    [N] sticky dropped-event flags
//   drop_cnt    [8] saturating dropped-event count
//               (present only when PROLONG_DROP_CNT_EN is defined)
// ---------------------------------------------------------------------------
module pulse_prolong_arb #(
    parameter int N    = 4,   // requesters, 2..8
    parameter int HOLD = 6,   // out_pulse high cycles per grant, 1..15
    parameter int GAP  = 3    // out_pulse low cycles after a grant, 1..15
) (
    input  logic                 clk1,
    input  logic                 nrst,
    input  logic [N-1:0]         req_pulse,
    output logic                 out_pulse,
    output logic [$clog2(N)-1:0] sel_id,
    output logic                 busy,
    output logic                 done_pulse,
    output logic [N-1:0]         pending,
    output logic [N-1:0]         overflow
`ifdef PROLONG_DROP_CNT_EN
    ,
    output logic [7:0]           drop_cnt
`endif
);

    localparam int         IW        = $clog2(N);
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD - 1);
    localparam logic [3:0] GAP_LOAD  = 4'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_GAP
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;      // cycles remaining in HOLD/GAP, counts down to 0
    logic [IW-1:0]  ptr_q;             // last granted index; search starts one past it
    logic           grant;
    logic           grant_found;
    logic [IW-1:0]  grant_idx;
    logic [IW-1:0]  cand;
    logic [N-1:0]   grant_mask;
    logic [N-1:0]   drops;
    logic [N-1:0]   pending_d;

    // Round-robin search over the registered pending flags.
    // NOTE: every variable written in an always_comb gets a default first,
    // otherwise an unassigned path infers a latch.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr_q) + k) % N);
            if (!grant_found && pending[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Next-state logic. A grant is issued from IDLE, or from the last GAP
    // cycle so back-to-back grants run at exactly HOLD+GAP cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    grant   = 1'b1;
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            S_HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_GAP: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (grant_found) begin
                    grant   = 1'b1;
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // A strobe from the requester being granted this cycle re-arms its flag
    // rather than counting as a drop, because the old flag is consumed now.
    always_comb begin
        grant_mask = '0;
        if (grant) begin
            grant_mask[grant_idx] = 1'b1;
        end
        drops     = req_pulse & pending & ~grant_mask;
        pending_d = (pending & ~grant_mask) | req_pulse;
    end

    assign out_pulse  = (state_q == S_HOLD);
    assign busy       = (state_q != S_IDLE);
    assign done_pulse = (state_q == S_GAP) && (cnt_q == GAP_LOAD);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk1 or negedge nrst) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            ptr_q    <= IW'(N - 1);   // requester 0 wins the first search
            sel_id   <= '0;
            pending  <= '0;
            overflow <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pending  <= pending_d;
            overflow <= overflow | drops;
            if (grant) begin
                ptr_q  <= grant_idx;
                sel_id <= grant_idx;
            end
        end
    end

`ifdef PROLONG_DROP_CNT_EN
    // Several requesters can drop in one cycle; add them all, clamp at 255.
    logic [8:0] drop_sum;

    always_comb begin
        drop_sum = {1'b0, drop_cnt} + 9'($countones(drops));
    end

    always_ff @(posedge clk1 or negedge nrst) begin
        if (!nrst) begin
            drop_cnt <= 8'd0;
        end else if (drop_sum > 9'd255) begin
            drop_cnt <= 8'hFF;
        end else begin
            drop_cnt <= drop_sum[7:0];
        end
    end
`else
    // Drop counter not built; overflow flags still record drops.
`endif

endmodule

// File: tb/tb_pulse_prolong_arb.sv
// ---------------------------------------------------------------------------
// tb_pulse_prolong_arb
//
// Scoreboard bench for pulse_prolong_arb (N=4, HOLD=6, GAP=3). The driver
// applies directed and random strobes and, from a timestamp-level reference
// model (grant times, pending set, round-robin pointer), pushes the expected
// per-cycle outputs and expected grant events into queues. An independent
// monitor on the falling edge pops and compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_pulse_prolong_arb;

    localparam int N    = 4;
    localparam int HOLD = 6;
    localparam int GAP  = 3;

    logic         clk1 = 1'b0;
    logic         nrst = 1'b0;
    logic [N-1:0] req_pulse = '0;
    logic         out_pulse;
    logic [1:0]   sel_id;
    logic         busy;
    logic         done_pulse;
    logic [N-1:0] pending;
    logic [N-1:0] overflow;
`ifdef PROLONG_DROP_CNT_EN
    logic [7:0]   drop_cnt;
`endif

    pulse_prolong_arb #(.N(N), .HOLD(HOLD), .GAP(GAP)) dut (
        .clk1       (clk1),
        .nrst       (nrst),
        .req_pulse  (req_pulse),
        .out_pulse  (out_pulse),
        .sel_id     (sel_id),
        .busy       (busy),
        .done_pulse (done_pulse),
        .pending    (pending),
        .overflow   (overflow)
`ifdef PROLONG_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk1 = ~clk1;

    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard queues ----------------
    typedef struct {
        logic [N-1:0] pend;
        logic [N-1:0] ovf;
        logic         out;
        logic         bsy;
        logic         done;
        logic [1:0]   sel;
        logic [7:0]   dcnt;
    } cyc_exp_t;

    typedef struct {
        int id;
        int start;
    } grant_exp_t;

    cyc_exp_t   cyc_q[$];
    grant_exp_t grant_q[$];

    // ---------------- reference model ----------------
    logic [N-1:0] m_pend;
    logic [N-1:0] m_ovf;
    int           m_ptr;
    int           m_sel;
    int           m_glast;   // cycle of the most recent grant decision
    int           m_dcnt;

    task automatic model_reset();
        m_pend  = '0;
        m_ovf   = '0;
        m_ptr   = N - 1;
        m_sel   = 0;
        m_glast = -1000;
        m_dcnt  = 0;
    endtask

    // One clock cycle: record what the DUT must show in this cycle, apply the
    // strobes, then advance the model by the arbitration rules.
    task automatic drive_cycle(input logic [N-1:0] r);
        cyc_exp_t     e;
        logic [N-1:0] gmask;
        logic [N-1:0] dr;
        int           d;
        int           gid;
        bit           found;
        @(posedge clk1);
        #1;
        d      = cyc - m_glast;
        e.pend = m_pend;
        e.ovf  = m_ovf;
        e.out  = (d >= 1) && (d <= HOLD);
        e.bsy  = (d >= 1) && (d <= HOLD + GAP);
        e.done = (d == HOLD + 1);
        e.sel  = 2'(m_sel);
        e.dcnt = 8'(m_dcnt);
        cyc_q.push_back(e);

        req_pulse = r;
        gmask     = '0;
        found     = 1'b0;
        gid       = 0;
        if (m_pend != '0 && cyc >= m_glast + HOLD + GAP) begin
            for (int k = 1; k <= N; k++) begin
                if (!found && m_pend[(m_ptr + k) % N]) begin
                    found = 1'b1;
                    gid   = (m_ptr + k) % N;
                end
            end
            grant_q.push_back('{id: gid, start: cyc + 1});
            m_glast    = cyc;
            m_ptr      = gid;
            m_sel      = gid;
            gmask[gid] = 1'b1;
        end
        dr     = r & m_pend & ~gmask;
        m_ovf  = m_ovf | dr;
        m_dcnt = m_dcnt + $countones(dr);
        if (m_dcnt > 255) m_dcnt = 255;
        m_pend = (m_pend & ~gmask) | r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle('0);
    endtask

    // ---------------- monitor ----------------
    logic prev_out = 1'b0;

    always @(negedge clk1) begin
        cyc_exp_t   e;
        grant_exp_t g;
        if (!nrst) begin
            prev_out = 1'b0;
        end else begin
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                check("outputs{pend,ovf,out,busy,done,sel}",
                      {pending, overflow, out_pulse, busy, done_pulse, sel_id},
                      {e.pend, e.ovf, e.out, e.bsy, e.done, e.sel});
`ifdef PROLONG_DROP_CNT_EN
                check("drop_cnt", drop_cnt, e.dcnt);
`endif
            end
            if (out_pulse && !prev_out) begin
                if (grant_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_unexpected: actual sel %0d required none (cycle %0d)", sel_id, cyc);
                end else begin
                    g = grant_q.pop_front();
                    check("grant_sel", sel_id, g.id);
                    check("grant_start", cyc, g.start);
                end
            end
            prev_out = out_pulse;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [N-1:0] r;
        model_reset();
        repeat (3) @(posedge clk1);
        #1;
        check("reset_out_pulse",  out_pulse,  1'b0);
        check("reset_busy",       busy,       1'b0);
        check("reset_done",       done_pulse, 1'b0);
        check("reset_sel",        sel_id,     2'd0);
        check("reset_pending",    pending,    4'd0);
        check("reset_overflow",   overflow,   4'd0);
        nrst = 1'b1;
        idle(5);

        // single event
        drive_cycle(4'b0100);
        idle(20);
        // three simultaneous requesters, then 0 and 3 together after grant to 3
        drive_cycle(4'b1011);
        idle(40);
        drive_cycle(4'b1001);
        idle(30);
        // drop on requester 1 while its flag is still pending
        drive_cycle(4'b0001);
        idle(2);
        drive_cycle(4'b0010);
        idle(1);
        drive_cycle(4'b0010);
        idle(30);
        // re-strobe in the grant cycle is not a drop
        drive_cycle(4'b0100);
        drive_cycle(4'b0100);
        idle(30);

        // random: heavy load first (drops, saturation), then sparse
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < N; b++) begin
                r[b] = (i < 700) ? ($urandom_range(1) == 0) : ($urandom_range(7) == 0);
            end
            drive_cycle(r);
        end
        idle(60);
        check("grant_queue_drained", grant_q.size(), 0);

        // reset in the middle of HOLD
        drive_cycle(4'b0001);
        idle(3);
        @(posedge clk1);
        #1;
        check("pre_reset_out_pulse", out_pulse, 1'b1);
        nrst = 1'b0;
        #1;
        check("abort_out_pulse", out_pulse,  1'b0);
        check("abort_busy",      busy,       1'b0);
        check("abort_done",      done_pulse, 1'b0);
        check("abort_pending",   pending,    4'd0);
        check("abort_overflow",  overflow,   4'd0);
        check("abort_sel",       sel_id,     2'd0);
`ifdef PROLONG_DROP_CNT_EN
        check("abort_drop_cnt",  drop_cnt,   8'd0);
`endif
        @(posedge clk1);
        #1;
        check("abort_no_done", done_pulse, 1'b0);
        @(posedge clk1);
        #1;
        nrst = 1'b1;
        model_reset();
        drive_cycle(4'b1000);
        idle(30);
        check("grant_queue_final", grant_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
